pc_fetch_sequencer: RTL



---
 rtl/pc_fetch_sequencer_pkg.sv | 19 +
 rtl/pc_fetch_sequencer_if.sv | 33 +++
 rtl/pc_fetch_sequencer_fetch_out_reg.sv | 36 +++
 rtl/pc_fetch_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer: default widths, reset vector,
// fetch FSM state encoding and a saturating counter helper.
package pc_fetch_sequencer_pkg;

  localparam int PC_WIDTH_DEF = 16;
  localparam int INSTR_WIDTH_DEF = 16;
  localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory port of the fetch sequencer: request channel plus
// single-strobe response channel.
interface pc_fetch_sequencer_if #(
  parameter int PC_WIDTH = 16,
  parameter int INSTR_WIDTH = 16
);

  // A request transfers on any cycle with imem_req_valid && imem_req_ready;
  // valid never waits on ready. A response is a one-cycle imem_resp_valid
  // strobe carrying imem_resp_data and cannot be back-pressured.
  logic                   imem_req_valid;
  logic [PC_WIDTH-1:0]    imem_req_addr;
  logic                   imem_req_ready;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/pc_fetch_sequencer_fetch_out_reg.sv
// Decode-facing holding register: loads a fetched word with its PC, holds
// while stalled, clears when consumed or flushed by a redirect.
module pc_fetch_sequencer_fetch_out_reg #(
  parameter int PC_WIDTH = 16,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc,
  input  logic                   flush,
  input  logic                   stall,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc
);

  // Flush beats load; data is left in place when valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= load_instr;
      instr_pc <= load_pc;
    end else if (valid && !stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and single-outstanding instruction fetch with redirect.
// Optional FETCH_PERF_EN adds saturating delivered/flush counters.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
  parameter logic [PC_WIDTH-1:0] PC_INCR = PC_WIDTH'(1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    branch_taken,
  input  logic [PC_WIDTH-1:0]     branch_target,
  input  logic                    stall,
  pc_fetch_sequencer_if.master    imem,
  output logic                    instr_valid,
  output logic [INSTR_WIDTH-1:0]  instr,
  output logic [PC_WIDTH-1:0]     instr_pc,
  output fetch_state_t            state_dbg
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]             perf_fetched,
  output logic [15:0]             perf_flushes
`endif
);

  fetch_state_t        state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PC_WIDTH-1:0] inflight_pc, inflight_pc_nxt;
  logic                drop, drop_nxt;
  logic                req_valid;
  logic                req_fire;
  logic                load;
  logic                slot_free;

  assign slot_free = !instr_valid || !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      inflight_pc <= '0;
      drop        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inflight_pc <= inflight_pc_nxt;
      drop        <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    inflight_pc_nxt = inflight_pc;
    drop_nxt        = drop;
    req_valid       = 1'b0;
    req_fire        = 1'b0;
    load            = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        req_valid = slot_free;
        req_fire  = slot_free && imem.imem_req_ready;
        if (req_fire) begin
          inflight_pc_nxt = pc;
          pc_nxt          = pc + PC_INCR;
          state_nxt       = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_resp_valid) begin
          drop_nxt  = 1'b0;
          load      = !drop && !branch_taken;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A response landing with the redirect is discarded on the spot, so only
    // a still-outstanding fetch needs the drop marker.
    if (branch_taken) begin
      pc_nxt = branch_target;
      if (req_fire || (state == WAIT && !imem.imem_resp_valid)) begin
        drop_nxt = 1'b1;
      end
    end
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc;
  assign state_dbg           = state;

  pc_fetch_sequencer_fetch_out_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_instr (imem.imem_resp_data),
    .load_pc    (inflight_pc),
    .flush      (branch_taken),
    .stall      (stall),
    .valid      (instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (load) perf_fetched <= sat_inc16(perf_fetched);
      if (branch_taken) perf_flushes <= sat_inc16(perf_flushes);
    end
  end
`endif

endmodule
